// File: rtl/uart_pkg.sv
// Shared constants and FSM state types for the buffered UART.
package uart_pkg;

   localparam logic [3:0] AddrData   = 4'h0;
   localparam logic [3:0] AddrStatus = 4'h4;
   localparam logic [3:0] AddrCtrl   = 4'h8;
   localparam logic [3:0] AddrLevel  = 4'hC;

   localparam int unsigned StatTxFull    = 0;
   localparam int unsigned StatRxNempty  = 1;
   localparam int unsigned StatTxEmpty   = 2;
   localparam int unsigned StatRxOvr     = 3;
   localparam int unsigned StatFrameErr  = 4;
   localparam int unsigned StatBrkPend   = 5;
   localparam int unsigned StatTxBusy    = 6;
   localparam int unsigned StatTxOvf     = 7;

   localparam int unsigned CtrlRxIrqEn   = 0;
   localparam int unsigned CtrlBrkIrqEn  = 1;
   localparam int unsigned CtrlClrSticky = 4;
   localparam int unsigned CtrlClrBrk    = 7;

   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read port and occupancy count.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned Aw = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [Aw-1:0]    wptr_q, rptr_q;
   logic [Aw:0]      count_q, count_d;
   logic             wr_en, rd_en;

   assign full  = (count_q == (Aw+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rptr_q];

   // A push at full is still accepted when a pop frees the slot this cycle.
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;

   always_comb begin
      count_d = count_q;
      unique case ({wr_en, rd_en})
         2'b10:   count_d = count_q + (Aw+1)'(1);
         2'b01:   count_d = count_q - (Aw+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (wr_en) wptr_q <= wptr_q + Aw'(1);
         if (rd_en) rptr_q <= rptr_q + Aw'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q] <= wdata;
   end

endmodule

// File: rtl/uart_fifo.sv
// Bus-mapped 8N1 UART with RX/TX FIFOs, break-character detection and level interrupt.
module uart_fifo #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned RX_DEPTH     = 16,
   parameter int unsigned TX_DEPTH     = 16,
   parameter int unsigned RX_THRESH    = 1,
   parameter logic [7:0]  BRK_CHAR     = 8'h03,
   parameter bit          BRK_EN       = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wr_val,
   input  logic [3:0]  bus_bytesel,
   output logic        bus_ack,
   output logic [31:0] bus_data,
   output logic        inter,
   input  logic        intack,
   input  logic        rxd,
   output logic        txd
);
   import uart_pkg::*;

   localparam int unsigned RxAw = $clog2(RX_DEPTH);
   localparam int unsigned TxAw = $clog2(TX_DEPTH);
   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [RxAw:0]   RxThresh = (RxAw+1)'(RX_THRESH);

   logic [3:0] addr;
   logic       wr, rd, cs_q;
   logic       unused_bus;

   assign addr       = bus_addr[3:0];
   assign wr         = cs && (bus_bytesel == 4'b0001);
   assign rd         = cs && (bus_bytesel != 4'b0001);
   assign unused_bus = ^{bus_addr[31:4], bus_wr_val[31:8]};

   // FIFOs
   logic            rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0]      rx_rdata;
   logic [RxAw:0]   rx_count;
   logic            tx_push, tx_pop, tx_full, tx_empty;
   logic [7:0]      tx_rdata;
   logic [TxAw:0]   tx_count;

   rx_state_e       rx_state_q, rx_state_d;
   logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]      rx_bit_q, rx_bit_d;
   logic [7:0]      rx_shift_q, rx_shift_d;
   logic            rx_s1_q, rx_s2_q, rx_s3_q;
   logic            rx_done, frame_err_set;

   sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .pop   (rx_pop),
      .wdata (rx_shift_q),
      .rdata (rx_rdata),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata (bus_wr_val[7:0]),
      .rdata (tx_rdata),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   // Pop only on the leading cycle of a cs run so a held access reads once.
   assign rx_pop  = rd && !cs_q && (addr == AddrData) && !rx_empty;
   assign tx_push = wr && (addr == AddrData);

   // RX path
   always_comb begin
      rx_state_d    = rx_state_q;
      rx_cnt_d      = rx_cnt_q;
      rx_bit_d      = rx_bit_q;
      rx_shift_d    = rx_shift_q;
      rx_done       = 1'b0;
      frame_err_set = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            if (rx_s3_q && !rx_s2_q) begin
               rx_state_d = RxStart;
               rx_cnt_d   = '0;
            end
         end
         RxStart: begin
            if (rx_cnt_q == CntHalf) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s2_q ? RxIdle : RxData;
            end else begin
               rx_cnt_d = rx_cnt_q + CntW'(1);
            end
         end
         RxData: begin
            if (rx_cnt_q == CntFull) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = RxStop;
            end else begin
               rx_cnt_d = rx_cnt_q + CntW'(1);
            end
         end
         RxStop: begin
            if (rx_cnt_q == CntFull) begin
               rx_state_d    = RxIdle;
               rx_done       = rx_s2_q;
               frame_err_set = !rx_s2_q;
            end else begin
               rx_cnt_d = rx_cnt_q + CntW'(1);
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   logic brk_set;
   assign brk_set = rx_done && BRK_EN && (rx_shift_q == BRK_CHAR);
   assign rx_push = rx_done && !brk_set;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_s3_q    <= 1'b1;
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_s1_q    <= rxd;
         rx_s2_q    <= rx_s1_q;
         rx_s3_q    <= rx_s2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   // TX path
   tx_state_e       tx_state_q, tx_state_d;
   logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]      tx_bit_q, tx_bit_d;
   logic [7:0]      tx_shift_q, tx_shift_d;
   logic            txd_q, txd_d;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_pop     = 1'b0;
      unique case (tx_state_q)
         TxIdle: begin
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_rdata;
               tx_cnt_d   = '0;
               tx_state_d = TxStart;
            end
         end
         TxStart: begin
            if (tx_cnt_q == CntFull) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TxData;
            end else begin
               tx_cnt_d = tx_cnt_q + CntW'(1);
            end
         end
         TxData: begin
            if (tx_cnt_q == CntFull) begin
               tx_cnt_d   = '0;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_bit_d   = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) tx_state_d = TxStop;
            end else begin
               tx_cnt_d = tx_cnt_q + CntW'(1);
            end
         end
         TxStop: begin
            if (tx_cnt_q == CntFull) begin
               tx_cnt_d = '0;
               // Chain straight into the next start bit when more data waits.
               if (!tx_empty) begin
                  tx_pop     = 1'b1;
                  tx_shift_d = tx_rdata;
                  tx_state_d = TxStart;
               end else begin
                  tx_state_d = TxIdle;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CntW'(1);
            end
         end
         default: tx_state_d = TxIdle;
      endcase
      unique case (tx_state_d)
         TxStart: txd_d = 1'b0;
         TxData:  txd_d = tx_shift_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         txd_q      <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
      end
   end

   assign txd = txd_q;

   // Flags, control and interrupt
   logic rx_ovr_q, frame_err_q, tx_ovf_q, brk_pend_q, brk_pend_d;
   logic rx_irq_en_q, brk_irq_en_q, inter_q, inter_d;
   logic ctrl_wr, clr_sticky, brk_clr;

   assign ctrl_wr    = wr && (addr == AddrCtrl);
   assign clr_sticky = ctrl_wr && bus_wr_val[CtrlClrSticky];
   assign brk_clr    = (intack && brk_pend_q) || (ctrl_wr && bus_wr_val[CtrlClrBrk]);
   assign brk_pend_d = brk_set || (brk_pend_q && !brk_clr);
   assign inter_d    = (rx_irq_en_q && (rx_count >= RxThresh)) || (brk_irq_en_q && brk_pend_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_ovr_q     <= 1'b0;
         frame_err_q  <= 1'b0;
         tx_ovf_q     <= 1'b0;
         brk_pend_q   <= 1'b0;
         rx_irq_en_q  <= 1'b0;
         brk_irq_en_q <= 1'b0;
         inter_q      <= 1'b0;
      end else begin
         rx_ovr_q    <= (rx_push && rx_full && !rx_pop) || (rx_ovr_q && !clr_sticky);
         frame_err_q <= frame_err_set || (frame_err_q && !clr_sticky);
         tx_ovf_q    <= (tx_push && tx_full && !tx_pop) || (tx_ovf_q && !clr_sticky);
         brk_pend_q  <= brk_pend_d;
         inter_q     <= inter_d;
         if (ctrl_wr) begin
            rx_irq_en_q  <= bus_wr_val[CtrlRxIrqEn];
            brk_irq_en_q <= bus_wr_val[CtrlBrkIrqEn];
         end
      end
   end

   assign inter = inter_q;

   // Bus read side
   logic [7:0]  status;
   logic [31:0] rd_data;

   always_comb begin
      status               = '0;
      status[StatTxFull]   = tx_full;
      status[StatRxNempty] = !rx_empty;
      status[StatTxEmpty]  = tx_empty;
      status[StatRxOvr]    = rx_ovr_q;
      status[StatFrameErr] = frame_err_q;
      status[StatBrkPend]  = brk_pend_q;
      status[StatTxBusy]   = !tx_empty || (tx_state_q != TxIdle);
      status[StatTxOvf]    = tx_ovf_q;
      rd_data = '0;
      if (rd) begin
         case (addr)
            AddrData:   rd_data = rx_empty ? 32'h0 : {24'h0, rx_rdata};
            AddrStatus: rd_data = {24'h0, status};
            AddrCtrl:   rd_data = {30'h0, brk_irq_en_q, rx_irq_en_q};
            AddrLevel:  rd_data = {16'h0, 8'(tx_count), 8'(rx_count)};
            default:    rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_q     <= 1'b0;
         bus_ack  <= 1'b0;
         bus_data <= '0;
      end else begin
         cs_q     <= cs;
         bus_ack  <= cs;
         bus_data <= rd_data;
      end
   end

endmodule
